// File: rtl/br_feedback_if.sv
// Resolution, predictor-feedback and redirect signals between execute and br_feedback.
interface br_feedback_if;
  logic        res_valid;
  logic        res_ready;
  logic        res_is_br;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        upd_ena;
  logic        fb_ena;
  logic        fb_taken_stat;
  logic [31:0] fb_pc;
  logic        mp_valid;
  logic [31:0] mp_target;

  // Execute/predictor side: drives resolutions and the update window.
  modport master (
    output res_valid, res_is_br, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target, upd_ena,
    input  res_ready, fb_ena, fb_taken_stat, fb_pc, mp_valid, mp_target
  );

  // br_feedback side.
  modport slave (
    input  res_valid, res_is_br, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target, upd_ena,
    output res_ready, fb_ena, fb_taken_stat, fb_pc, mp_valid, mp_target
  );
endinterface

// File: rtl/br_feedback.sv
// Branch resolution feedback: queues conditional-branch outcomes for predictor
// training, raises a one-cycle redirect on mispredicts and keeps statistics.
module br_feedback #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  br_feedback_if.slave     bus,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_mp
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned QCNT_W = PTR_W + 1;

  logic [31:0]           q_pc    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_taken;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [QCNT_W-1:0]     count;

  logic        accept;
  logic        enq;
  logic        deq;
  logic        not_empty;
  logic [31:0] pc_plus4;
  logic [31:0] actual_next;
  logic [31:0] pred_next;
  logic        mispredict;

  // Handshake, queue view and next-PC comparison.
  always_comb begin
    not_empty         = (count != '0);
    bus.res_ready     = (count < QCNT_W'(FIFO_DEPTH));
    bus.fb_ena        = not_empty && bus.upd_ena;
    bus.fb_pc         = not_empty ? q_pc[rd_ptr] : 32'd0;
    bus.fb_taken_stat = not_empty ? q_taken[rd_ptr] : 1'b0;
    accept            = bus.res_valid && bus.res_ready;
    enq               = accept && bus.res_is_br;
    deq               = bus.fb_ena;
    pc_plus4          = bus.res_pc + 32'd4;
    actual_next       = bus.res_taken ? bus.res_target : pc_plus4;
    pred_next         = bus.res_pred_taken ? bus.res_pred_target : pc_plus4;
    mispredict        = accept && (actual_next != pred_next);
  end

  // Queue storage; entries are only visible through count, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= bus.res_pc;
      q_taken[wr_ptr] <= bus.res_taken;
    end
  end

  // Pointers, occupancy, redirect pulse and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.mp_valid  <= 1'b0;
      bus.mp_target <= 32'd0;
      stat_br       <= '0;
      stat_mp       <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + QCNT_W'(1);
        2'b01:   count <= count - QCNT_W'(1);
        default: count <= count;
      endcase
      bus.mp_valid <= mispredict;
      if (mispredict) bus.mp_target <= actual_next;
      if (enq && (stat_br != '1)) stat_br <= stat_br + CNT_W'(1);
      if (mispredict && (stat_mp != '1)) stat_mp <= stat_mp + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_feedback.sv
// Directed bench for br_feedback: training queue, redirects, statistics, reset.
module tb_br_feedback;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stat_br;
  logic [31:0] stat_mp;
  logic [1:0]  stat_br2;
  logic [1:0]  stat_mp2;
  int          tests = 0;
  int          fails = 0;

  br_feedback_if bus ();
  br_feedback_if bus2 ();

  br_feedback #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stat_br(stat_br), .stat_mp(stat_mp)
  );

  // Narrow-counter instance for saturation.
  br_feedback #(.FIFO_DEPTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .stat_br(stat_br2), .stat_mp(stat_mp2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic is_br, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    bus.res_valid       = 1'b1;
    bus.res_is_br       = is_br;
    bus.res_pc          = pc;
    bus.res_taken       = taken;
    bus.res_target      = tgt;
    bus.res_pred_taken  = ptaken;
    bus.res_pred_target = ptgt;
  endtask

  task automatic idle();
    bus.res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.res_valid = 1'b0; bus.res_is_br = 1'b0; bus.res_pc = 32'd0; bus.res_taken = 1'b0;
    bus.res_target = 32'd0; bus.res_pred_taken = 1'b0; bus.res_pred_target = 32'd0;
    bus.upd_ena = 1'b0;
    bus2.res_valid = 1'b0; bus2.res_is_br = 1'b0; bus2.res_pc = 32'd0; bus2.res_taken = 1'b0;
    bus2.res_target = 32'd0; bus2.res_pred_taken = 1'b0; bus2.res_pred_target = 32'd0;
    bus2.upd_ena = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_fb_ena", 32'(bus.fb_ena), 32'd0);
    chk("rst_fb_pc", bus.fb_pc, 32'd0);
    chk("rst_fb_taken", 32'(bus.fb_taken_stat), 32'd0);
    chk("rst_mp_valid", 32'(bus.mp_valid), 32'd0);
    chk("rst_mp_target", bus.mp_target, 32'd0);
    chk("rst_stat_br", stat_br, 32'd0);
    chk("rst_stat_mp", stat_mp, 32'd0);
    chk("rst_res_ready", 32'(bus.res_ready), 32'd1);
    rst = 1'b0;

    // Correctly predicted taken branch
    bus.upd_ena = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 32'h140, 1'b1, 32'h140);
    tick();
    idle();
    chk("ok_fb_ena", 32'(bus.fb_ena), 32'd1);
    chk("ok_fb_pc", bus.fb_pc, 32'h100);
    chk("ok_fb_taken", 32'(bus.fb_taken_stat), 32'd1);
    chk("ok_mp_valid", 32'(bus.mp_valid), 32'd0);
    chk("ok_stat_br", stat_br, 32'd1);
    tick();
    chk("ok_drained", 32'(bus.fb_ena), 32'd0);

    // Mispredicted not-taken branch
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h180);
    tick();
    idle();
    chk("mp_valid", 32'(bus.mp_valid), 32'd1);
    chk("mp_target", bus.mp_target, 32'h204);
    chk("mp_stat_mp", stat_mp, 32'd1);
    chk("mp_stat_br", stat_br, 32'd2);
    chk("mp_fb_taken", 32'(bus.fb_taken_stat), 32'd0);
    tick();
    chk("mp_pulse_end", 32'(bus.mp_valid), 32'd0);
    chk("mp_target_hold", bus.mp_target, 32'h204);

    // JAL mispredict: redirect but no training
    drive(1'b0, 32'h300, 1'b1, 32'h400, 1'b1, 32'h3F0);
    tick();
    idle();
    chk("jal_mp_valid", 32'(bus.mp_valid), 32'd1);
    chk("jal_mp_target", bus.mp_target, 32'h400);
    chk("jal_fb_ena", 32'(bus.fb_ena), 32'd0);
    chk("jal_stat_br", stat_br, 32'd2);
    chk("jal_stat_mp", stat_mp, 32'd2);
    tick();
    chk("jal_fb_ena2", 32'(bus.fb_ena), 32'd0);

    // Fill with update window closed: 5 offered, 4 accepted
    bus.upd_ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 16), 1'(i), 32'h2000, 1'(i), 32'h2000);
      #1;
      chk($sformatf("fill_ready_%0d", i), 32'(bus.res_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    chk("fill_stat_br", stat_br, 32'd6);
    chk("fill_fb_ena", 32'(bus.fb_ena), 32'd0);
    chk("fill_head", bus.fb_pc, 32'h1000);
    tick();
    chk("fill_persist", bus.fb_pc, 32'h1000);
    bus.upd_ena = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_ena_%0d", i), 32'(bus.fb_ena), 32'd1);
      chk($sformatf("drain_pc_%0d", i), bus.fb_pc, 32'h1000 + 32'(i * 16));
      chk($sformatf("drain_tk_%0d", i), 32'(bus.fb_taken_stat), 32'(i & 1));
      tick();
    end
    chk("drain_empty", 32'(bus.fb_ena), 32'd0);
    chk("drain_no_mp", stat_mp, 32'd2);

    // Full queue with simultaneous drain and offer
    bus.upd_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 32'h700);
    bus.upd_ena = 1'b1;
    #1;
    chk("full_ready", 32'(bus.res_ready), 32'd0);
    chk("full_fb_ena", 32'(bus.fb_ena), 32'd1);
    tick();
    bus.upd_ena = 1'b0;
    #1;
    chk("full_ready_after", 32'(bus.res_ready), 32'd1);
    chk("full_head_after", bus.fb_pc, 32'h504);
    tick();
    idle();
    chk("full_refilled", 32'(bus.res_ready), 32'd0);
    chk("full_stat_br", stat_br, 32'd11);
    bus.upd_ena = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_pc_%0d", i), bus.fb_pc, (i < 3) ? 32'h504 + 32'(i * 4) : 32'h600);
      tick();
    end
    chk("wrap_empty", 32'(bus.fb_ena), 32'd0);

    // Back-to-back mispredicts and counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      bus2.res_valid = 1'b1; bus2.res_is_br = 1'b1; bus2.res_pc = 32'h700 + 32'(i * 4);
      bus2.res_taken = 1'b1; bus2.res_target = 32'h800 + 32'(i * 16);
      bus2.res_pred_taken = 1'b0; bus2.res_pred_target = 32'h0;
      tick();
      chk($sformatf("b2b_mp_valid_%0d", i), 32'(bus2.mp_valid), 32'd1);
      chk($sformatf("b2b_mp_target_%0d", i), bus2.mp_target, 32'h800 + 32'(i * 16));
      chk($sformatf("sat_mp_%0d", i), 32'(stat_mp2), (i < 2) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat_br_%0d", i), 32'(stat_br2), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    bus2.res_valid = 1'b0;
    tick();
    chk("b2b_end", 32'(bus2.mp_valid), 32'd0);

    // Reset wins over a mispredicting accept with entries queued
    bus.upd_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h900 + 32'(i * 4), 1'b1, 32'hA00, 1'b1, 32'hA00);
      tick();
    end
    drive(1'b1, 32'h90C, 1'b1, 32'hB00, 1'b0, 32'h0);
    bus.upd_ena = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rstq_fb_ena", 32'(bus.fb_ena), 32'd0);
    chk("rstq_fb_pc", bus.fb_pc, 32'd0);
    chk("rstq_mp_valid", 32'(bus.mp_valid), 32'd0);
    chk("rstq_mp_target", bus.mp_target, 32'd0);
    chk("rstq_stat_br", stat_br, 32'd0);
    chk("rstq_stat_mp", stat_mp, 32'd0);
    chk("rstq_ready", 32'(bus.res_ready), 32'd1);
    tick();
    chk("rstq_no_pulse", 32'(bus.mp_valid), 32'd0);
    chk("rstq_fb_ena2", 32'(bus.fb_ena), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
